// File: rtl/pe_pkg.sv
// Shared types and default geometry for the RAVEN iterative processing element.
package pe_pkg;

  typedef enum logic [1:0] {
    MODE_GEMM = 2'b00,
    MODE_DIV  = 2'b01,
    MODE_EXP  = 2'b10,
    MODE_LOG  = 2'b11
  } pe_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } pe_state_e;

  localparam int DEF_INT_BW = 5;
  localparam int DEF_FRA_BW = 3;
  localparam int DEF_MUL_BW = 16;
  localparam int DEF_ACC_BW = 32;
  localparam int DEF_ITER   = 8;

  function automatic int opd_bw(input int int_bw, input int fra_bw);
    return 1 + int_bw + fra_bw;
  endfunction

  // Operand encoding of 1.0 in Q(INT.FRA).
  function automatic int opd_one(input int fra_bw);
    return 1 << fra_bw;
  endfunction

endpackage

// File: rtl/opd_clamp.sv
// Saturates an accumulator value (2*FRA fraction bits) to the signed Q(INT.FRA)
// operand range, dropping FRA fraction bits with floor rounding.
module opd_clamp
  import pe_pkg::*;
#(
  parameter int INT_BW = DEF_INT_BW,
  parameter int FRA_BW = DEF_FRA_BW,
  parameter int ACC_BW = DEF_ACC_BW
) (
  input  logic signed [ACC_BW-1:0]          acc_i,
  output logic signed [INT_BW+FRA_BW:0]     opd_o
);

  localparam int OPD_BW = INT_BW + FRA_BW + 1;
  localparam int HI_BIT = INT_BW + 2 * FRA_BW;

  localparam logic signed [ACC_BW-1:0] POS_LIM = ACC_BW'((64'sd1 <<< HI_BIT) - 64'sd1);
  localparam logic signed [ACC_BW-1:0] NEG_LIM = ACC_BW'(-(64'sd1 <<< HI_BIT));

  localparam logic signed [OPD_BW-1:0] OPD_MAX = {1'b0, {(OPD_BW-1){1'b1}}};
  localparam logic signed [OPD_BW-1:0] OPD_MIN = {1'b1, {(OPD_BW-1){1'b0}}};

  always_comb begin
    opd_o = acc_i[HI_BIT:FRA_BW];
    if (acc_i > POS_LIM) begin
      opd_o = OPD_MAX;
    end else if (acc_i < NEG_LIM) begin
      opd_o = OPD_MIN;
    end
  end

endmodule

// File: rtl/pe_r_iter.sv
// RAVEN processing element: systolic GEMM MAC cell plus Horner-rule unary mode.
// Define PE_ACC_SAT_EN to make accumulator additions saturate instead of wrap.
module pe_r_iter
  import pe_pkg::*;
#(
  parameter int INT_BW = DEF_INT_BW,
  parameter int FRA_BW = DEF_FRA_BW,
  parameter int MUL_BW = DEF_MUL_BW,
  parameter int ACC_BW = DEF_ACC_BW,
  parameter int ITER   = DEF_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        gemm_uno,
  input  logic              start,
  input  logic              coef_valid,
  input  logic [MUL_BW-1:0] x_i,
  input  logic [MUL_BW-1:0] wc_i,
  input  logic [ACC_BW-1:0] o_i,
  output logic [MUL_BW-1:0] wc_o,
  output logic [ACC_BW-1:0] o_o,
  output logic              busy,
  output logic              done
);

  localparam int OPD_BW = opd_bw(INT_BW, FRA_BW);
  localparam int PRD_BW = 2 * OPD_BW;
  localparam int CNT_BW = $clog2(ITER) + 1;
  localparam int VW_BW  = OPD_BW + 2;

  localparam logic [CNT_BW-1:0]       CNT_LAST = CNT_BW'(ITER - 1);
  localparam logic signed [VW_BW-1:0] ONE_W    = VW_BW'(opd_one(FRA_BW));

  function automatic logic signed [ACC_BW-1:0] acc_add(
    input logic signed [ACC_BW-1:0] a,
    input logic signed [ACC_BW-1:0] b
  );
    logic signed [ACC_BW-1:0] s;
    s = a + b;
`ifdef PE_ACC_SAT_EN
    if ((a[ACC_BW-1] == b[ACC_BW-1]) && (s[ACC_BW-1] != a[ACC_BW-1])) begin
      s = a[ACC_BW-1] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  function automatic logic signed [ACC_BW-1:0] prod_ext(input logic signed [PRD_BW-1:0] p);
    return {{(ACC_BW-PRD_BW){p[PRD_BW-1]}}, p};
  endfunction

  pe_state_e state_q, state_d;
  logic [MUL_BW-1:0]        wreg_q, wreg_d;
  logic signed [OPD_BW-1:0] ireg_q, ireg_d;
  logic signed [OPD_BW-1:0] vreg_q, vreg_d;
  logic signed [ACC_BW-1:0] oreg_q, oreg_d;
  logic [CNT_BW-1:0]        cnt_q, cnt_d;

  pe_mode_e mode;
  logic signed [OPD_BW-1:0] x_op, w_op, c_op, fb_op, v_sat;
  logic signed [PRD_BW-1:0] gemm_prod, iter_prod;
  logic signed [ACC_BW-1:0] gemm_sum, iter_sum, coef_ext, v_acc;
  logic signed [VW_BW-1:0]  x_w, v_raw;
  logic                     unused_x;

  assign mode     = pe_mode_e'(gemm_uno);
  assign x_op     = x_i[OPD_BW-1:0];
  assign w_op     = wreg_q[OPD_BW-1:0];
  assign c_op     = wc_i[OPD_BW-1:0];
  assign unused_x = ^x_i[MUL_BW-1:OPD_BW];

  // GEMM path: registered weight times registered activation plus north partial sum.
  assign gemm_prod = w_op * ireg_q;
  assign gemm_sum  = acc_add(prod_ext(gemm_prod), o_i);

  // Horner step: feedback is the accumulator re-quantised to an operand.
  opd_clamp #(
    .INT_BW (INT_BW),
    .FRA_BW (FRA_BW),
    .ACC_BW (ACC_BW)
  ) u_fb_clamp (
    .acc_i (oreg_q),
    .opd_o (fb_op)
  );

  assign iter_prod = fb_op * vreg_q;
  assign coef_ext  = {{(ACC_BW-OPD_BW-FRA_BW){c_op[OPD_BW-1]}}, c_op, {FRA_BW{1'b0}}};
  assign iter_sum  = acc_add(prod_ext(iter_prod), coef_ext);

  // Argument transform, computed two bits wider so 1.0 +/- x cannot wrap before saturation.
  always_comb begin
    x_w = {{2{x_op[OPD_BW-1]}}, x_op};
    unique case (mode)
      MODE_DIV: v_raw = ONE_W - x_w;
      MODE_LOG: v_raw = x_w - ONE_W;
      default:  v_raw = x_w;
    endcase
  end

  // Lift v to accumulator scale so the shared clamp slices it straight back.
  assign v_acc = {{(ACC_BW-VW_BW-FRA_BW){v_raw[VW_BW-1]}}, v_raw, {FRA_BW{1'b0}}};

  opd_clamp #(
    .INT_BW (INT_BW),
    .FRA_BW (FRA_BW),
    .ACC_BW (ACC_BW)
  ) u_v_clamp (
    .acc_i (v_acc),
    .opd_o (v_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wreg_q  <= '0;
      ireg_q  <= '0;
      vreg_q  <= '0;
      oreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wreg_q  <= wreg_d;
      ireg_q  <= ireg_d;
      vreg_q  <= vreg_d;
      oreg_q  <= oreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wreg_d  = wc_i;
    ireg_d  = ireg_q;
    vreg_d  = vreg_q;
    oreg_d  = oreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mode == MODE_GEMM) begin
          ireg_d = x_op;
          oreg_d = gemm_sum;
        end else if (start) begin
          state_d = ST_ITER;
          vreg_d  = v_sat;
          oreg_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_ITER: begin
        if (coef_valid) begin
          oreg_d = iter_sum;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wc_o = wreg_q;
  assign o_o  = oreg_q;
  assign busy = (state_q == ST_ITER);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_pe_r_iter.sv
// Self-checking bench for pe_r_iter at default widths with ITER=3.
module tb_pe_r_iter;

  localparam int IT = 3;
`ifdef PE_ACC_SAT_EN
  localparam logic [31:0] SAT_EXP = 32'h7FFFFFFF;
`else
  localparam logic [31:0] SAT_EXP = 32'h80000170;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  gemm_uno;
  logic        start, coef_valid;
  logic [15:0] x_i, wc_i, wc_o;
  logic [31:0] o_i, o_o;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  pe_r_iter #(
    .INT_BW (5),
    .FRA_BW (3),
    .MUL_BW (16),
    .ACC_BW (32),
    .ITER   (IT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gemm_uno   (gemm_uno),
    .start      (start),
    .coef_valid (coef_valid),
    .x_i        (x_i),
    .wc_i       (wc_i),
    .o_i        (o_i),
    .wc_o       (wc_o),
    .o_o        (o_o),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic longint opd(input logic [15:0] v);
    longint t;
    t = longint'(v & 16'h01FF);
    if (t >= 256) t -= 512;
    return t;
  endfunction

  function automatic longint sx32(input logic [31:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic logic [31:0] addm(input longint a, input longint b);
    longint s;
    s = a + b;
`ifdef PE_ACC_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return 32'(s);
  endfunction

  // acc has 6 fraction bits; operand has 3: floor-divide by 8, saturate to [-256, 255].
  function automatic longint clampm(input longint a);
    if (a > 2047) return 255;
    if (a < -2048) return -256;
    return a >>> 3;
  endfunction

  function automatic longint vfun(input logic [1:0] m, input logic [15:0] x);
    longint v;
    case (m)
      2'b01:   v = 8 - opd(x);
      2'b11:   v = opd(x) - 8;
      default: v = opd(x);
    endcase
    if (v > 255) v = 255;
    if (v < -256) v = -256;
    return v;
  endfunction

  function automatic logic [31:0] hstep(input logic [31:0] acc, input longint v, input logic [15:0] c);
    return addm(clampm(sx32(acc)) * v, opd(c) * 8);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic gemm_apply(input logic [15:0] wc, input logic [15:0] x, input logic [31:0] oi,
                            input logic [31:0] req, input string nm);
    gemm_uno   = 2'b00;
    start      = 1'($urandom);
    coef_valid = 1'($urandom);
    wc_i       = wc;
    x_i        = x;
    o_i        = $urandom;
    tick();
    chk({nm, ".wc_o"}, 32'(wc_o), 32'(wc));
    wc_i = 16'($urandom);
    x_i  = 16'($urandom);
    o_i  = oi;
    tick();
    chk({nm, ".o_o"}, o_o, req);
  endtask

  // smode: 0 coef_valid steady, 1 two stalls after the first coefficient, 2 random stalls.
  task automatic unary(input logic [1:0] m, input logic [15:0] x, input logic [15:0] c0,
                       input logic [15:0] c1, input logic [15:0] c2, input int smode,
                       input string nm, output logic [31:0] res);
    logic [15:0] c [IT];
    longint      v;
    logic [31:0] acc;
    int          k, cyc, stalls;
    bit          vld;
    c[0] = c0; c[1] = c1; c[2] = c2;
    v = vfun(m, x);
    acc = 32'd0;
    k = 0; cyc = 0; stalls = 0;
    gemm_uno   = m;
    x_i        = x;
    start      = 1'b1;
    coef_valid = 1'b1;
    wc_i       = c0;
    o_i        = $urandom;
    tick();
    chk({nm, ".start_busy"}, 32'({busy, done}), 32'b10);
    chk({nm, ".start_clear"}, o_o, 32'd0);
    while (k < IT && cyc < 60) begin
      case (smode)
        0:       vld = 1'b1;
        1:       vld = !(k == 1 && stalls < 2);
        default: vld = ($urandom_range(0, 2) != 0);
      endcase
      coef_valid = vld;
      wc_i       = vld ? c[k] : 16'($urandom);
      start      = 1'($urandom);
      gemm_uno   = 2'($urandom);
      x_i        = 16'($urandom);
      o_i        = $urandom;
      tick();
      cyc++;
      if (vld) begin
        acc = hstep(acc, v, c[k]);
        k++;
      end else begin
        stalls++;
      end
      chk({nm, ".step_o"}, o_o, acc);
      chk({nm, ".busy_done"}, 32'({busy, done}), (k < IT) ? 32'b10 : 32'b01);
    end
    if (k < IT) begin
      checks++;
      errors++;
      $display("FAIL %s.budget: only %0d of %0d steps in %0d cycles", nm, k, IT, cyc);
    end
    res        = acc;
    start      = 1'b0;
    gemm_uno   = 2'b01;
    coef_valid = 1'b0;
    tick();
    chk({nm, ".after_done"}, 32'({busy, done}), 32'b00);
    chk({nm, ".hold"}, o_o, acc);
  endtask

  typedef struct {
    logic [15:0] wc;
    logic [15:0] x;
    logic [31:0] oi;
    logic [31:0] req;
  } gvec_t;

  typedef struct {
    logic [1:0]  m;
    logic [15:0] x;
    logic [15:0] c0, c1, c2;
    logic [31:0] req;
  } uvec_t;

  gvec_t gv [6];
  uvec_t uv [7];

  initial begin
    logic [31:0] res;
    logic [15:0] rw, rx;
    logic [31:0] ro;

    gv[0] = '{16'd16,    16'd24,    32'd100,       32'd484};
    gv[1] = '{16'h01F8,  16'd24,    32'd0,         32'hFFFFFF40};
    gv[2] = '{16'h00FF,  16'h00FF,  32'd0,         32'd65025};
    gv[3] = '{16'h0100,  16'h0100,  32'd5,         32'd65541};
    gv[4] = '{16'hFE10,  16'hFE18,  32'd0,         32'd384};
    gv[5] = '{16'd16,    16'd24,    32'h7FFFFFF0,  SAT_EXP};

    uv[0] = '{2'b10, 16'd8,     16'd4,    16'd8,    16'd8,    32'd160};
    uv[1] = '{2'b01, 16'd4,     16'd8,    16'd8,    16'd8,    32'd112};
    uv[2] = '{2'b11, 16'd8,     16'd8,    16'd8,    16'd8,    32'd64};
    uv[3] = '{2'b10, 16'h00FF,  16'h00FF, 16'h00FF, 16'h00FF, 32'd67065};
    uv[4] = '{2'b10, 16'h01F8,  16'd8,    16'd8,    16'd8,    32'd64};
    uv[5] = '{2'b01, 16'h0100,  16'd8,    16'd0,    16'd0,    32'd65025};
    uv[6] = '{2'b11, 16'h0100,  16'd8,    16'd0,    16'd0,    32'd65536};

    rst = 1'b1; gemm_uno = 2'b01; start = 1'b0; coef_valid = 1'b0;
    x_i = '0; wc_i = '0; o_i = '0;
    #1;
    chk("reset.wc_o", 32'(wc_o), 32'd0);
    chk("reset.o_o", o_o, 32'd0);
    chk("reset.busy_done", 32'({busy, done}), 32'b00);
    tick();
    rst = 1'b0;
    tick();

    // Spec case 3 by hand: exp, x=1.0, coefficients 4, 8, 8.
    gemm_uno = 2'b10; x_i = 16'd8; start = 1'b1; coef_valid = 1'b1; wc_i = 16'd4;
    tick();
    start = 1'b0;
    tick(); chk("exp.s1", o_o, 32'd32);
    wc_i = 16'd8;
    tick(); chk("exp.s2", o_o, 32'd96);
    chk("exp.s2_busy", 32'({busy, done}), 32'b10);
    tick(); chk("exp.s3", o_o, 32'd160);
    chk("exp.done_t4", 32'({busy, done}), 32'b01);
    coef_valid = 1'b0;
    tick(); chk("exp.done_pulse", 32'({busy, done}), 32'b00);
    chk("exp.result_held", o_o, 32'd160);

    // Reset in the middle of an evaluation.
    start = 1'b1; wc_i = 16'd4; coef_valid = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wc_i = 16'd8;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst.o_o", o_o, 32'd0);
    chk("midrst.wc_o", 32'(wc_o), 32'd0);
    chk("midrst.busy_done", 32'({busy, done}), 32'b00);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst.after", 32'({busy, done}), 32'b00);
    chk("midrst.after_o", o_o, 32'd0);

    for (int i = 0; i < 6; i++) begin
      gemm_apply(gv[i].wc, gv[i].x, gv[i].oi, gv[i].req, $sformatf("gemm%0d", i));
    end

    for (int i = 0; i < 7; i++) begin
      unary(uv[i].m, uv[i].x, uv[i].c0, uv[i].c1, uv[i].c2, 0, $sformatf("uno%0d", i), res);
      chk($sformatf("uno%0d.result", i), res, uv[i].req);
    end

    // Case 3 with two stalls after the first coefficient and stray start pulses.
    unary(2'b10, 16'd8, 16'd4, 16'd8, 16'd8, 1, "stall", res);
    chk("stall.result", res, 32'd160);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rw = 16'($urandom);
        rx = 16'($urandom);
        ro = $urandom;
        if ($urandom_range(0, 3) == 0) ro = 32'h7FFFFF00 + 32'($urandom_range(0, 255));
        gemm_apply(rw, rx, ro, addm(opd(rw) * opd(rx), sx32(ro)), $sformatf("rgemm%0d", i));
      end else begin
        unary(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 2, $sformatf("runo%0d", i), res);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
